// File: rtl/mc_bus_ctrl_unit_if.sv
// rtl/mc_bus_ctrl_unit_if.sv - fetch and data bus handshake bundle between the control unit and the APB bridge
interface mc_bus_ctrl_unit_if;
  logic       ifReq;
  logic       ifReady;
  logic       busReq;
  logic       busReady;
  logic       busErr;
  logic       dataWe;
  logic [2:0] busSize;

  modport master (
    output ifReq, busReq, dataWe, busSize,
    input  ifReady, busReady, busErr
  );

  modport slave (
    input  ifReq, busReq, dataWe, busSize,
    output ifReady, busReady, busErr
  );
endinterface

// File: rtl/mc_bus_ctrl_unit.sv
// rtl/mc_bus_ctrl_unit.sv - multi-cycle RV32I control FSM with bus wait states, timeout and fault trap
// Optional performance counters are built only when PERF_CNT_EN is defined.
module mc_bus_ctrl_unit #(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instrCode,
  mc_bus_ctrl_unit_if.master   bus,
  output logic                 irEn,
  output logic                 PCEn,
  output logic                 regFileWe,
  output logic [3:0]           aluControl,
  output logic                 aluSrcMuxSel,
  output logic [2:0]           RFWDSrcMuxSel,
  output logic                 branch,
  output logic                 jal,
  output logic                 jalr,
  output logic                 trap,
  output logic [1:0]           trapCause,
  output logic                 halted,
  output logic [CNT_W-1:0]     instret,
  output logic [CNT_W-1:0]     cycles
);

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam int         TO_W       = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_R_EXE, S_I_EXE, S_B_EXE, S_LU_EXE, S_AU_EXE, S_J_EXE,
    S_JL_EXE, S_S_EXE, S_S_MEM, S_L_EXE, S_L_MEM, S_L_WB, S_TRAP, S_HALT
  } state_t;

  state_t          state, state_next;
  logic [1:0]      cause_q, cause_next;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit, waiting;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;
  assign opcode      = instrCode[6:0];
  assign funct3      = instrCode[14:12];
  assign unused_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  logic       if_req, ir_en, pc_en, rf_we, alu_src, br_c, jal_c, jalr_c;
  logic       bus_req, data_we, trap_c, halt_c;
  logic [2:0] rfwd, bus_size;
  logic [3:0] alu_ctl;

  // The last allowed wait cycle is only a timeout if ready is still low in it.
  assign to_hit  = (BUS_TIMEOUT > 0) && (to_cnt == TO_W'(BUS_TIMEOUT - 1));
  assign waiting = (state == S_FETCH) || (state == S_S_MEM) || (state == S_L_MEM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      cause_q <= 2'b00;
      to_cnt  <= '0;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state_next != state) to_cnt <= '0;
      else if (waiting)        to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    if_req = 1'b0; ir_en = 1'b0; pc_en = 1'b0; rf_we = 1'b0; alu_src = 1'b0;
    br_c = 1'b0; jal_c = 1'b0; jalr_c = 1'b0; bus_req = 1'b0; data_we = 1'b0;
    trap_c = 1'b0; halt_c = 1'b0; rfwd = 3'b000;
    alu_ctl  = {instrCode[30], funct3};
    bus_size = funct3;
    case (state)
      S_FETCH: begin
        if_req = 1'b1;
        if (bus.ifReady) begin
          ir_en      = 1'b1;
          state_next = S_DECODE;
        end else if (to_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_TYPE_R:  state_next = S_R_EXE;
          OP_TYPE_I:  state_next = S_I_EXE;
          OP_TYPE_B:  state_next = S_B_EXE;
          OP_TYPE_LU: state_next = S_LU_EXE;
          OP_TYPE_AU: state_next = S_AU_EXE;
          OP_TYPE_J:  state_next = S_J_EXE;
          OP_TYPE_JL: state_next = S_JL_EXE;
          OP_TYPE_S:  state_next = S_S_EXE;
          OP_TYPE_L:  state_next = S_L_EXE;
          default: begin
            state_next = S_TRAP;
            cause_next = 2'b11;
          end
        endcase
      end
      S_R_EXE:  begin rf_we = 1'b1; pc_en = 1'b1; state_next = S_FETCH; end
      S_I_EXE: begin
        rf_we = 1'b1; alu_src = 1'b1; pc_en = 1'b1; state_next = S_FETCH;
        // Only shifts use funct7[5]; for other immediates bit 30 is immediate data.
        alu_ctl = (funct3 == 3'b101) ? {instrCode[30], funct3} : {1'b0, funct3};
      end
      S_B_EXE:  begin br_c = 1'b1; pc_en = 1'b1; state_next = S_FETCH; end
      S_LU_EXE: begin rf_we = 1'b1; rfwd = 3'b010; pc_en = 1'b1; state_next = S_FETCH; end
      S_AU_EXE: begin rf_we = 1'b1; rfwd = 3'b011; pc_en = 1'b1; state_next = S_FETCH; end
      S_J_EXE: begin
        rf_we = 1'b1; rfwd = 3'b100; jal_c = 1'b1; pc_en = 1'b1; state_next = S_FETCH;
      end
      S_JL_EXE: begin
        rf_we = 1'b1; rfwd = 3'b100; jal_c = 1'b1; jalr_c = 1'b1; pc_en = 1'b1;
        alu_ctl = ALU_ADD; state_next = S_FETCH;
      end
      S_S_EXE: begin alu_src = 1'b1; alu_ctl = ALU_ADD; state_next = S_S_MEM; end
      S_S_MEM: begin
        bus_req = 1'b1; data_we = 1'b1; alu_src = 1'b1;
        if (bus.busReady) begin
          if (bus.busErr) begin
            state_next = S_TRAP;
            cause_next = 2'b01;
          end else begin
            pc_en      = 1'b1;
            state_next = S_FETCH;
          end
        end else if (to_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_L_EXE: begin alu_src = 1'b1; alu_ctl = ALU_ADD; rfwd = 3'b001; state_next = S_L_MEM; end
      S_L_MEM: begin
        bus_req = 1'b1; rfwd = 3'b001;
        if (bus.busReady) begin
          if (bus.busErr) begin
            state_next = S_TRAP;
            cause_next = 2'b01;
          end else begin
            state_next = S_L_WB;
          end
        end else if (to_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_L_WB: begin rf_we = 1'b1; rfwd = 3'b001; pc_en = 1'b1; state_next = S_FETCH; end
      S_TRAP: begin trap_c = 1'b1; state_next = S_HALT; end
      S_HALT: begin halt_c = 1'b1; alu_ctl = '0; bus_size = '0; end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset gates the decoded outputs so an in-flight bus request drops without waiting for a clock.
  assign bus.ifReq     = reset & if_req;
  assign bus.busReq    = reset & bus_req;
  assign bus.dataWe    = reset & data_we;
  assign bus.busSize   = reset ? bus_size : 3'b000;
  assign irEn          = reset & ir_en;
  assign PCEn          = reset & pc_en;
  assign regFileWe     = reset & rf_we;
  assign aluControl    = reset ? alu_ctl : 4'b0000;
  assign aluSrcMuxSel  = reset & alu_src;
  assign RFWDSrcMuxSel = reset ? rfwd : 3'b000;
  assign branch        = reset & br_c;
  assign jal           = reset & jal_c;
  assign jalr          = reset & jalr_c;
  assign trap          = reset & trap_c;
  assign halted        = reset & halt_c;
  assign trapCause     = cause_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycles_q, instret_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      if (state != S_HALT) cycles_q <= cycles_q + 1'b1;
      if (pc_en)           instret_q <= instret_q + 1'b1;
    end
  end
  assign cycles  = cycles_q;
  assign instret = instret_q;
`else
  assign cycles  = '0;
  assign instret = '0;
`endif

endmodule
